vga_line_loader: RTL and testbench
==================================

// Module: vga_line_loader
// PURPOSE
//  Write-side partner of the VGA line FIFO. Responds to the display controller's load-request,
//  load-line and clear strobes: fetches one active video line of RGB pixels from frame memory and
//  pushes them into the dual-clock line FIFO ahead of scan-out. Runs in the memory clock domain (iCLK).
// PARAMETERS
//  H_ACTIVE     1920   pixels per line = FIFO words per load
//  V_ACTIVE     1080   lines per frame; iLOAD_VLINE >= V_ACTIVE is clamped to V_ACTIVE-1
//  ADDR_W       22     memory word address width
//  BASE_ADDR    0      word address of pixel (0,0)
//  FIFO_DEPTH   2048   line FIFO depth in words
//  MAX_OUTST    4      maximum memory reads in flight
// PORTS
//  iCLK           in   1       memory-domain clock
//  iRST_N         in   1       asynchronous active-low reset
//  iLOAD_REQ      in   1       load strobe from display domain (>=2 display clocks wide)
//  iLOAD_VLINE    in   13      line to load; stable while iLOAD_REQ is high and for one line afterwards
//  iFIFO_CLEAR    in   1       frame-start clear strobe from display domain
//  oMEM_ADDR      out  ADDR_W  read word address
//  oMEM_RD        out  1       read request; accepted on a cycle with oMEM_RD=1 and iMEM_WAIT=0
//  iMEM_WAIT      in   1       memory stall
//  iMEM_RDVALID   in   1       read data valid, in order, any latency >= 1
//  iMEM_DATA      in   24      {R,G,B} pixel data
//  oFIFO_WDATA    out  24      FIFO write data
//  oFIFO_WREQ     out  1       FIFO write strobe
//  iFIFO_WUSEDW   in   12      FIFO words used (write side)
//  oFIFO_ACLR     out  1       FIFO asynchronous clear, one iCLK pulse
//  oBUSY          out  1       line fetch in progress
//  oOVERRUN       out  1       sticky: request dropped while busy; cleared by clear strobe
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters 0. Reset mid-line abandons the fetch, no FIFO writes follow.
//  CDC: iLOAD_REQ and iFIFO_CLEAR each pass a 2-FF synchroniser followed by a rising-edge detector.
//   iLOAD_VLINE is sampled only in ARM, >=3 cycles after the edge, so it is stable by then.
//  Clear edge: oFIFO_ACLR=1 for exactly 1 cycle; oOVERRUN<=0; any fetch aborts (see ABORT).
//  FSM:
//   IDLE  - on load edge go to ARM; oBUSY=0.
//   ARM   - line=min(VLINE,V_ACTIVE-1); base<=BASE_ADDR+line*H_ACTIVE (registered, 1 cycle);
//           rd_cnt=wr_cnt=0; oBUSY=1; go to FETCH.
//   FETCH - issue reads while rd_cnt<H_ACTIVE, outst<MAX_OUTST and
//           iFIFO_WUSEDW+outst<FIFO_DEPTH. oMEM_ADDR=base+rd_cnt and oMEM_RD hold during iMEM_WAIT.
//           On rd_cnt==H_ACTIVE go to DRAIN.
//   DRAIN - wait until wr_cnt==H_ACTIVE, then go to IDLE.
//   ABORT - entered on clear edge from ARM/FETCH/DRAIN. Issue no reads; discard returning data
//           until outst==0, then go to IDLE. oBUSY=1 while in ABORT.
//  Data path: each iMEM_RDVALID gives oFIFO_WREQ=1 with oFIFO_WDATA=iMEM_DATA on the next cycle,
//   wr_cnt++ (outside ABORT). Latency from data valid to FIFO write: 1 cycle.
//  outst: +1 on an accepted read, -1 on rdvalid; both in one cycle leave it unchanged. Never exceeds MAX_OUTST.
//  Load edge while not IDLE: request dropped; oOVERRUN<=1.
//  Load edge and clear edge in the same cycle: clear takes priority; load is dropped without setting OVERRUN.
//  Address arithmetic: ADDR_W-bit unsigned; parameters are chosen so there is no overflow.
//   Elaboration asserts BASE_ADDR+H_ACTIVE*V_ACTIVE <= 2**ADDR_W and H_ACTIVE <= FIFO_DEPTH.
// STRUCTURE
//  Shared package vga_pkg: H_ACTIVE/V_ACTIVE defaults, pixel typedef (24-bit {R,G,B}), FSM state enum.
//  One sub-module: sync_pulse (2-FF sync + rising-edge detect), instantiated twice (load, clear).
//  Outstanding counter, address generator and FSM live in the top level.
// TESTING
//  1) Reset, then VLINE=5 with req pulse, zero-wait memory with latency 3 -> 1920 reads at addresses
//     9600..11519, 1920 FIFO writes in order, oBUSY falls after the last write.
//  2) Random iMEM_WAIT and latency 1..8 -> data order preserved, outst never exceeds 4,
//     exactly H_ACTIVE writes per line.
//  3) Hold iFIFO_WUSEDW=2046 with MAX_OUTST=4 -> at most 2 reads outstanding; issue resumes as WUSEDW drops.
//  4) Clear strobe mid-FETCH with 3 reads outstanding -> oFIFO_ACLR pulses for 1 cycle, 3 returns
//     discarded, no FIFO writes, FSM back in IDLE.
//  5) Second load req during DRAIN -> oOVERRUN=1, current line completes intact; next clear -> oOVERRUN=0.
//  6) VLINE=4000 -> line clamped to 1079, first address 2071680; iRST_N low mid-line -> outputs 0 immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA line-loader types and default timing constants
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1920;
  localparam int V_ACTIVE_DEF = 1080;

  typedef logic [23:0] pixel_t;  // {R,G,B}

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FETCH,
    ST_DRAIN,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/sync_pulse.sv
// rtl/sync_pulse.sv - 2-FF synchroniser followed by a rising-edge detector
module sync_pulse (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic i_async,
  output logic o_pulse
);

  // [1:0] are the synchroniser stages, [2] holds the previous synchronised value
  logic [2:0] r_sync;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_sync <= '0;
    else         r_sync <= {r_sync[1:0], i_async};
  end

  assign o_pulse = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/vga_line_loader.sv
// rtl/vga_line_loader.sv - fetches one video line from frame memory into the line FIFO
module vga_line_loader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int ADDR_W     = 22,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 2048,
  parameter int MAX_OUTST  = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLOAD_REQ,
  input  logic [12:0]       iLOAD_VLINE,
  input  logic              iFIFO_CLEAR,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic              oMEM_RD,
  input  logic              iMEM_WAIT,
  input  logic              iMEM_RDVALID,
  input  pixel_t            iMEM_DATA,
  output pixel_t            oFIFO_WDATA,
  output logic              oFIFO_WREQ,
  input  logic [11:0]       iFIFO_WUSEDW,
  output logic              oFIFO_ACLR,
  output logic              oBUSY,
  output logic              oOVERRUN
);

  localparam int CNT_W = $clog2(H_ACTIVE + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  if (64'(BASE_ADDR) + 64'(H_ACTIVE) * 64'(V_ACTIVE) > (64'd1 << ADDR_W)) begin : g_addr_chk
    $error("frame does not fit in the memory address space");
  end
  if (H_ACTIVE > FIFO_DEPTH) begin : g_depth_chk
    $error("line FIFO cannot hold a full line");
  end

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_line;
  logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt;
  logic [OUT_W-1:0]  r_outst;
  logic              r_rd_hold, r_aclr, r_overrun, r_wreq;
  pixel_t            r_wdata;
  logic              w_load_edge, w_clr_edge, w_can_issue, w_accept;

  sync_pulse u_sync_load (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .i_async (iLOAD_REQ),
    .o_pulse (w_load_edge)
  );

  sync_pulse u_sync_clear (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .i_async (iFIFO_CLEAR),
    .o_pulse (w_clr_edge)
  );

  assign w_line = (int'(iLOAD_VLINE) >= V_ACTIVE) ? ADDR_W'(V_ACTIVE - 1) : ADDR_W'(iLOAD_VLINE);

  // Count in-flight reads against FIFO room so every returned word always fits
  assign w_can_issue = (r_rd_cnt < CNT_W'(H_ACTIVE)) &&
                       (r_outst < OUT_W'(MAX_OUTST)) &&
                       (int'(iFIFO_WUSEDW) + int'(r_outst) < FIFO_DEPTH);
  assign w_accept    = oMEM_RD & ~iMEM_WAIT;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_load_edge && !w_clr_edge) w_next = ST_ARM;
      ST_ARM:   w_next = w_clr_edge ? ST_ABORT : ST_FETCH;
      ST_FETCH: begin
        if (w_clr_edge)                         w_next = ST_ABORT;
        else if (r_rd_cnt == CNT_W'(H_ACTIVE))  w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_clr_edge)                         w_next = ST_ABORT;
        else if (r_wr_cnt == CNT_W'(H_ACTIVE))  w_next = ST_IDLE;
      end
      ST_ABORT: if (r_outst == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oBUSY   = 1'b0;
    oMEM_RD = 1'b0;
    case (r_state)
      ST_IDLE:  ;
      ST_FETCH: begin
        oBUSY   = 1'b1;
        oMEM_RD = r_rd_hold | w_can_issue;
      end
      default:  oBUSY = 1'b1;
    endcase
  end

  assign oMEM_ADDR   = oMEM_RD ? r_base + ADDR_W'(r_rd_cnt) : '0;
  assign oFIFO_WDATA = r_wdata;
  assign oFIFO_WREQ  = r_wreq;
  assign oFIFO_ACLR  = r_aclr;
  assign oOVERRUN    = r_overrun;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_base    <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_outst   <= '0;
      r_rd_hold <= 1'b0;
      r_aclr    <= 1'b0;
      r_overrun <= 1'b0;
      r_wreq    <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_aclr <= w_clr_edge;
      if (w_clr_edge)                              r_overrun <= 1'b0;
      else if (w_load_edge && r_state != ST_IDLE)  r_overrun <= 1'b1;

      r_wreq <= iMEM_RDVALID && (r_state != ST_ABORT);
      if (iMEM_RDVALID) r_wdata <= iMEM_DATA;

      case ({w_accept, iMEM_RDVALID})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   r_outst <= r_outst - OUT_W'(1);
        default: ;
      endcase

      // A stalled request must stay up until taken, unless the fetch is being aborted
      r_rd_hold <= oMEM_RD && iMEM_WAIT && !w_clr_edge;

      if (r_state == ST_ARM) begin
        r_base   <= ADDR_W'(BASE_ADDR) + w_line * ADDR_W'(H_ACTIVE);
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_accept) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        if (iMEM_RDVALID && r_state != ST_ABORT) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_line_loader.sv
// tb/tb_vga_line_loader.sv - scoreboard bench for vga_line_loader
module tb_vga_line_loader;

  localparam int H = 1920;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic [12:0] vline = '0;
  logic        fifo_clear = 1'b0;
  logic [21:0] o_mem_addr;
  logic        o_mem_rd;
  logic        mem_wait = 1'b0;
  logic        mem_rdvalid = 1'b0;
  logic [23:0] mem_data = '0;
  logic [23:0] o_fifo_wdata;
  logic        o_fifo_wreq;
  logic [11:0] usedw = '0;
  logic        o_fifo_aclr;
  logic        o_busy;
  logic        o_overrun;

  always #5 clk = ~clk;

  vga_line_loader dut (
    .iCLK         (clk),
    .iRST_N       (rst_n),
    .iLOAD_REQ    (load_req),
    .iLOAD_VLINE  (vline),
    .iFIFO_CLEAR  (fifo_clear),
    .oMEM_ADDR    (o_mem_addr),
    .oMEM_RD      (o_mem_rd),
    .iMEM_WAIT    (mem_wait),
    .iMEM_RDVALID (mem_rdvalid),
    .iMEM_DATA    (mem_data),
    .oFIFO_WDATA  (o_fifo_wdata),
    .oFIFO_WREQ   (o_fifo_wreq),
    .iFIFO_WUSEDW (usedw),
    .oFIFO_ACLR   (o_fifo_aclr),
    .oBUSY        (o_busy),
    .oOVERRUN     (o_overrun)
  );

  typedef struct {
    logic [23:0] d;
    int unsigned rdy;
  } rd_t;

  logic [21:0] exp_addr[$];
  logic [23:0] exp_data[$];
  rd_t         pend[$];

  int          n_checks = 0, n_pass = 0;
  int unsigned cyc = 0;
  bit          wait_rand = 0, stall = 0;
  int unsigned lat_min = 3, lat_max = 3;
  int          model_outst = 0, max_outst = 0, n_accept = 0, n_writes = 0, n_aclr = 0, lat_err = 0;
  bit          prev_valid = 0;

  function automatic logic [23:0] pix(input logic [21:0] a);
    return {2'b00, a} ^ 24'h5A3C96;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %0d expected none", nm, act);
  endtask

  // Memory model: in-order returns with per-read latency, optional random wait
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend.delete();
      mem_rdvalid = 1'b0;
      mem_wait    = 1'b0;
      mem_data    = '0;
      model_outst = 0;
    end else begin
      if (pend.size() > 0 && !stall && pend[0].rdy <= cyc) begin
        mem_rdvalid = 1'b1;
        mem_data    = pend[0].d;
        void'(pend.pop_front());
        model_outst--;
      end else begin
        mem_rdvalid = 1'b0;
      end
      mem_wait = wait_rand && ($urandom_range(0, 2) == 0);
      #1;
      if (o_mem_rd && !mem_wait) begin
        if (exp_addr.size() == 0) bad("unexpected_read", 32'(o_mem_addr));
        else chk("rd_addr", 32'(o_mem_addr), 32'(exp_addr.pop_front()));
        pend.push_back('{d: pix(o_mem_addr), rdy: cyc + $urandom_range(lat_min, lat_max)});
        model_outst++;
        n_accept++;
        if (model_outst > max_outst) max_outst = model_outst;
      end
    end
  end

  // Write-side monitor: pops the expected pixel on every FIFO write
  always @(negedge clk) begin
    #2;
    if (o_fifo_aclr) n_aclr++;
    if (o_fifo_wreq) begin
      n_writes++;
      if (!prev_valid) lat_err++;
      if (exp_data.size() == 0) bad("unexpected_write", 32'(o_fifo_wdata));
      else chk("wdata", 32'(o_fifo_wdata), 32'(exp_data.pop_front()));
    end
    prev_valid = mem_rdvalid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int vl, input int n_addr, input int n_data);
    int          line;
    int          k;
    logic [21:0] base;
    line = (vl >= 1080) ? 1079 : vl;
    base = 22'(line * H);
    for (int i = 0; i < n_addr; i++) exp_addr.push_back(base + 22'(i));
    for (int i = 0; i < n_data; i++) exp_data.push_back(pix(base + 22'(i)));
    @(negedge clk);
    vline    = 13'(vl);
    load_req = 1'b1;
    cycles(2);
    load_req = 1'b0;
    k = 0;
    while (!o_busy && k < 10) begin @(negedge clk); k++; end
    chk("busy_rise", 32'(o_busy), 1);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (o_busy && k < 20000) begin @(negedge clk); k++; end
    chk(nm, 32'(o_busy), 0);
  endtask

  task automatic clear_pulse();
    fifo_clear = 1'b1;
    cycles(2);
    fifo_clear = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_rd"},    32'(o_mem_rd), 0);
    chk({nm, "_addr"},  32'(o_mem_addr), 0);
    chk({nm, "_wreq"},  32'(o_fifo_wreq), 0);
    chk({nm, "_wdata"}, 32'(o_fifo_wdata), 0);
    chk({nm, "_aclr"},  32'(o_fifo_aclr), 0);
    chk({nm, "_busy"},  32'(o_busy), 0);
    chk({nm, "_ovr"},   32'(o_overrun), 0);
  endtask

  initial begin
    int w0, k;
    cycles(2);
    chk_zero_outputs("reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

    // 1) line 5, zero wait, latency 3: addresses 9600..11519
    w0 = n_writes;
    load(5, H, H);
    wait_idle("t1_idle");
    chk("t1_writes", 32'(n_writes - w0), H);
    chk("t1_addr_left", 32'(exp_addr.size()), 0);
    chk("t1_data_left", 32'(exp_data.size()), 0);

    // 2) random wait, latency 1..8, two lines
    wait_rand = 1; lat_min = 1; lat_max = 8; max_outst = 0;
    w0 = n_writes;
    load(0, H, H);
    wait_idle("t2a_idle");
    chk("t2a_writes", 32'(n_writes - w0), H);
    w0 = n_writes;
    load(1079, H, H);
    wait_idle("t2b_idle");
    chk("t2b_writes", 32'(n_writes - w0), H);
    chk("t2_outst_le4", 32'(max_outst <= 4), 1);
    chk("t2_data_left", 32'(exp_data.size()), 0);

    // 3) FIFO nearly full: only 2 reads in flight until it drains
    wait_rand = 0; lat_min = 3; lat_max = 3; max_outst = 0;
    usedw = 12'd2046;
    w0 = n_writes;
    load(7, H, H);
    cycles(300);
    chk("t3_max_outst", 32'(max_outst), 2);
    chk("t3_still_busy", 32'(o_busy), 1);
    usedw = 12'd0;
    wait_idle("t3_idle");
    chk("t3_writes", 32'(n_writes - w0), H);

    // 4) clear mid-fetch with 3 reads outstanding
    stall = 1; usedw = 12'd2045;
    w0 = n_writes;
    load(10, 3, 0);
    k = 0;
    while (model_outst != 3 && k < 100) begin @(negedge clk); k++; end
    chk("t4_outst3", 32'(model_outst), 3);
    n_aclr = 0;
    clear_pulse();
    cycles(6);
    chk("t4_aclr_once", 32'(n_aclr), 1);
    chk("t4_abort_busy", 32'(o_busy), 1);
    stall = 0;
    wait_idle("t4_idle");
    cycles(5);
    chk("t4_no_writes", 32'(n_writes - w0), 0);
    chk("t4_outst0", 32'(model_outst), 0);
    chk("t4_aclr_total", 32'(n_aclr), 1);
    chk("t4_ovr", 32'(o_overrun), 0);
    usedw = 12'd0;

    // 5) second request during DRAIN sets overrun; line still completes
    lat_min = 8; lat_max = 8;
    n_accept = 0;
    w0 = n_writes;
    load(2, H, H);
    k = 0;
    while (n_accept < H && k < 20000) begin @(negedge clk); k++; end
    chk("t5_all_issued", 32'(n_accept), H);
    load_req = 1'b1;
    cycles(2);
    load_req = 1'b0;
    cycles(4);
    chk("t5_overrun", 32'(o_overrun), 1);
    chk("t5_drain_busy", 32'(o_busy), 1);
    wait_idle("t5_idle");
    chk("t5_writes", 32'(n_writes - w0), H);
    cycles(10);
    chk("t5_no_restart", 32'(o_busy), 0);
    chk("t5_overrun_sticky", 32'(o_overrun), 1);
    clear_pulse();
    cycles(5);
    chk("t5_overrun_clr", 32'(o_overrun), 0);

    // 6) out-of-range line clamps to 1079 (first address 2071680); reset mid-line
    lat_min = 3; lat_max = 3;
    w0 = n_writes;
    load(4000, H, H);
    k = 0;
    while (n_writes - w0 < 100 && k < 2000) begin @(negedge clk); k++; end
    chk("t6_progress", 32'(n_writes - w0 >= 100), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    exp_addr.delete();
    exp_data.delete();
    w0 = n_writes;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    chk("t6_no_writes_after_rst", 32'(n_writes - w0), 0);
    chk("t6_idle", 32'(o_busy), 0);
    chk("latency_1cycle", 32'(lat_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
